// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM states and frame config layout.
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ID_W      = 3;
  localparam int unsigned CFG_W     = 5;
  localparam int unsigned CFG_DSIZE = 0;
  localparam int unsigned CFG_PEN   = 1;
  localparam int unsigned CFG_PMODE = 2;
  localparam int unsigned CFG_STOP  = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND       = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4
  } state_t;

  // Frame configuration as seen by uart_tx; field order matches the CFG_* offsets.
  typedef struct packed {
    logic       stop;
    logic [1:0] pmode;
    logic       pen;
    logic       dsize;
  } tx_cfg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr+1, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       grant_idx,
  output logic             found
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  int unsigned pos;

  // Scan requesters starting just past the last winner; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(ptr) + 32'd1 + k) % N_REQ;
      if (!found && req[IW'(pos)]) begin
        found            = 1'b1;
        grant[IW'(pos)]  = 1'b1;
        grant_idx        = 3'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte sources with round-robin grants,
// per-requester frame config, start timeout and a minimum inter-frame gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned GAP_CYCLES    = 0,
  parameter int unsigned START_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [8*N_REQ-1:0]     req_data,
  input  logic [5*N_REQ-1:0]     req_cfg,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       req_done,
  output logic [N_REQ-1:0]       req_err,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic [7:0]             tx_data,
  output logic                   tx_data_size,
  output logic                   tx_parity_en,
  output logic                   tx_stop_bit_size,
  output logic [1:0]             tx_parity_mode,
  output logic                   tx_send,
  input  logic                   tx_ready
);

  localparam int unsigned TW = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
  // Gap counter only needs to reach GAP_CYCLES-1 before leaving GAP.
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t             state, state_nxt;
  logic [TW-1:0]      tcnt, tcnt_nxt;
  logic [GW-1:0]      gcnt, gcnt_nxt;
  logic [2:0]         grant_nxt;
  logic [DATA_W-1:0]  data_nxt, sel_data;
  tx_cfg_t            cfg_q, cfg_nxt, sel_cfg;
  logic [N_REQ-1:0]   ack_nxt, done_nxt, err_nxt;
  logic [N_REQ-1:0]   win_onehot, grant_hot;
  logic [2:0]         win_idx;
  logic               win_any;

  // grant_id doubles as the round-robin pointer (last granted index).
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (grant_id),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .found     (win_any)
  );

  assign grant_hot        = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign tx_data_size     = cfg_q.dsize;
  assign tx_parity_en     = cfg_q.pen;
  assign tx_parity_mode   = cfg_q.pmode;
  assign tx_stop_bit_size = cfg_q.stop;

  // Select the winning requester's byte and config.
  always_comb begin
    sel_data = '0;
    sel_cfg  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_cfg  = req_cfg[i*CFG_W +: CFG_W];
      end
    end
  end

  // Next-state, counters and next values of all registered outputs.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    gcnt_nxt  = gcnt;
    grant_nxt = grant_id;
    data_nxt  = tx_data;
    cfg_nxt   = cfg_q;
    ack_nxt   = '0;
    done_nxt  = '0;
    err_nxt   = '0;
    case (state)
      IDLE: begin
        if (win_any && tx_ready) begin
          state_nxt = SEND;
          grant_nxt = win_idx;
          data_nxt  = sel_data;
          cfg_nxt   = sel_cfg;
          ack_nxt   = win_onehot;
        end
      end
      SEND: begin
        state_nxt = WAIT_START;
        tcnt_nxt  = '0;
      end
      WAIT_START: begin
        if (!tx_ready) begin
          state_nxt = WAIT_DONE;
        end else if (32'(tcnt) + 32'd1 >= START_TIMEOUT) begin
          // Counter reaches START_TIMEOUT on this edge and saturates there.
          tcnt_nxt  = TW'(START_TIMEOUT);
          err_nxt   = grant_hot;
          gcnt_nxt  = '0;
          state_nxt = GAP;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          done_nxt  = grant_hot;
          gcnt_nxt  = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (32'(gcnt) + 32'd1 >= GAP_CYCLES) begin
          state_nxt = IDLE;
        end else begin
          gcnt_nxt = gcnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tcnt     <= '0;
      gcnt     <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      cfg_q    <= '0;
      req_ack  <= '0;
      req_done <= '0;
      req_err  <= '0;
      tx_send  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tcnt     <= tcnt_nxt;
      gcnt     <= gcnt_nxt;
      grant_id <= grant_nxt;
      tx_data  <= data_nxt;
      cfg_q    <= cfg_nxt;
      req_ack  <= ack_nxt;
      req_done <= done_nxt;
      req_err  <= err_nxt;
      tx_send  <= (state_nxt == SEND);
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx transmitter between N_REQ byte sources.
- Each requester supplies a byte and its own frame configuration: data size, parity and stop bits.
- The block grants one requester and latches its byte and config onto the transmitter port. It pulses send, then tracks ready through frame start and frame end.
- It enforces a minimum idle gap before the next grant. It sits between the system-side producers and uart_tx, and runs in the same clk domain as uart_tx's clk.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, minimum clk cycles spent in GAP after a frame completes (0..255). With 0, GAP lasts exactly 1 cycle.
- START_TIMEOUT, 1023, maximum clk cycles to wait for tx_ready to fall after send. On expiry the frame is aborted as lost.

Ports:
- clk  in  1  system clock, same clock that feeds uart_tx clk
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i has a byte pending
- req_data  in  8*N_REQ  byte of requester i, bits [8i+7:8i]
- req_cfg  in  5*N_REQ  per requester {stop_bit_size, parity_mode[1:0], parity_en, data_size}, bits [5i+4:5i]
- req_ack  out  N_REQ  one-cycle pulse: requester i's byte captured; requester may change data/valid next cycle
- req_done  out  N_REQ  one-cycle pulse: requester i's frame finished (tx_ready high again)
- req_err  out  N_REQ  one-cycle pulse: start timeout for requester i
- grant_id  out  3  index of current or last granted requester
- busy  out  1  high in every state except IDLE
- tx_data  out  8  to uart_tx data
- tx_data_size, tx_parity_en, tx_stop_bit_size  out  1 each  to uart_tx config
- tx_parity_mode  out  2  to uart_tx config
- tx_send  out  1  to uart_tx send
- tx_ready  in  1  from uart_tx ready

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; counters 0. The same rst also resets uart_tx.
- A reset mid-frame returns the block to IDLE. No done or err pulse is issued for the aborted frame.
- State IDLE: if any req_valid and tx_ready, go to SEND next cycle. Otherwise stay.
- Grant selection in IDLE: first valid index searching from (last_grant+1) mod N_REQ upward, wrapping.
- On the IDLE->SEND edge, register in the same cycle:
  - grant_id <= winner;
  - tx_data <= winner's req_data;
  - tx_* config <= winner's req_cfg;
  - req_ack[winner] <= 1 for one cycle.
- State SEND (1 cycle): tx_send=1. Next state WAIT_START. Timeout counter cleared.
- State WAIT_START: tx_send=0.
  - On tx_ready==0, go to WAIT_DONE.
  - Otherwise the counter increments. At count==START_TIMEOUT, pulse req_err[grant_id] and go to GAP.
- State WAIT_DONE: on tx_ready==1, pulse req_done[grant_id] and go to GAP.
- State GAP: counter counts up to GAP_CYCLES, then go to IDLE.
- tx_data and tx_* config are held constant from SEND entry until IDLE re-entry. uart_tx samples data mid-frame, so mid-frame changes are forbidden.
- req_valid is sampled only in IDLE. A valid deasserted before grant is simply skipped. No ack is issued without a grant.
- Only one of req_ack, req_done, req_err is asserted per cycle, and only for bit grant_id.
- The round-robin pointer updates on grant, including grants that later time out.
- Timeout counter width: clog2(START_TIMEOUT+1); it saturates and does not wrap.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants IDLE/SEND/WAIT_START/WAIT_DONE/GAP;
  - config field offsets (CFG_DSIZE=0, CFG_PEN=1, CFG_PMODE=2..3, CFG_STOP=4);
  - CFG_W=5.
- One sub-module rr_arbiter: N_REQ request vector plus pointer in; one-hot grant and encoded index out; purely combinational.
- FSM, counters and output registers live in uart_tx_arbiter.

Test Plan:
1. Single requester: req_valid=0001, data 0x55, cfg 5'b00011 (8-bit, parity even... per field map). Required: ack[0] in cycle after grant, tx_send exactly 1 cycle, tx_data=0x55 held through the frame, done[0] when tx_ready rises, busy low after the gap.
2. All four requesters valid, pointer 0, bytes 0xA0..0xA3. Required: grant order 1,2,3,0 and exactly four done pulses in that order.
3. GAP_CYCLES=10, requester 2 continuously valid. Required: 11 clk cycles from done[2] to the next tx_send.
4. Config switch: requester 0 sends 7-bit with no parity, requester 1 sends 8-bit with odd parity and 2 stop bits. Required: tx_* config matches each grant and is stable for the whole frame. Serial line frames decode correctly: 9 vs 12 bit times.
5. tx_ready held high (uart_tx clock stopped), START_TIMEOUT=20. Required: err[grant_id] pulses 21 cycles after tx_send, no done pulse, and arbitration resumes after the gap.
6. rst asserted for one cycle during WAIT_DONE. Required: next cycle all outputs 0, state IDLE, no done/err, and a fresh request is granted normally afterwards.
